ext_bus_host: RTL
=================

# ext_bus_host

Host-side initiator for the 36-bit EXT_BUS CD mailbox protocol: it plays the HPS role against the core's extension responder. It periodically polls CD_GET (0x34), detects new core messages via the 8-bit request counter, and reads the 48-bit message. It also issues CD_SET (0x35) transactions carrying 48-bit replies. Used in standalone/simulation builds and as a synthesizable bus master on the sys side of EXT_BUS.

## Interface
Parameters:
- POLL_DIV, 1024: clk_sys cycles between poll starts (≥16).
- STB_GAP, 3: cycles from one strobe to the next; the sample happens on the last of them (≥2).
- IDLE_GAP, 4: cycles ext_enable stays low after every transaction (≥2).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ext_enable  out  1  EXT_BUS[34]; high for the whole transaction.
- ext_strobe  out  1  EXT_BUS[33]; one-cycle pulse per word.
- ext_dout  out  16  EXT_BUS[31:16]; word presented with the strobe.
- ext_din  in  16  EXT_BUS[15:0]; responder output.
- ext_dout_en  in  1  EXT_BUS[32]; responder claims the command.
- msg_data  out  48  last message read by CD_GET.
- msg_valid  out  1  one-cycle pulse; msg_data is valid.
- msg_lost  out  1  qualifies msg_valid; the counter advanced by more than 1.
- rsp_data  in  48  reply payload for CD_SET.
- rsp_valid  in  1  reply offered.
- rsp_ready  out  1  reply accepted on rsp_valid & rsp_ready.
- busy  out  1  a transaction or idle gap is in progress.
- no_dev  out  1  sticky; a command was not claimed (ext_dout_en low at the first sample).

## Operation
- States: IDLE, STROBE, WAIT, GAP.
- IDLE:
  - rsp_ready=1.
  - A rsp handshake latches rsp_data and starts a SET. This has priority over a poll.
  - Otherwise, when the poll counter expires, start a GET.
- Each word is sent as follows:
  - STROBE: 1 cycle, ext_strobe=1, ext_dout=word.
  - WAIT: STB_GAP-1 cycles.
  - ext_din and ext_dout_en are sampled on the last WAIT cycle.
- GET sequence:
  - Word 0 = 0x0034. Its sample gives the counter cnt = ext_din[7:0].
  - If cnt == last_cnt, end the transaction.
  - Otherwise send three words of 0x0000. Their samples give msg_data[15:0], [31:16] and [47:32], in that order.
  - Then pulse msg_valid, set msg_lost = ((cnt - last_cnt) mod 256) > 1, and update last_cnt = cnt.
- SET sequence: words 0x0035, rsp[15:0], rsp[31:16], rsp[47:32]; ext_din is ignored.
- Word-0 sample with ext_dout_en=0: set no_dev, abort to GAP, no msg_valid. A latched reply is dropped.
- GAP:
  - ext_enable=0, ext_strobe=0, ext_dout=0 for IDLE_GAP cycles, then go to IDLE.
  - The poll counter reloads when a GET starts.
- last_cnt resets to 0x00. The first poll after reset therefore reports any nonzero counter.
- Poll expiry during a SET is held pending and served after the GAP.

## Timing
- Reset values: ext_enable=0, ext_strobe=0, ext_dout=0, msg_data=0, msg_valid=0, msg_lost=0, rsp_ready=0 (driven 1 once in IDLE), busy=0, no_dev=0, last_cnt=0, poll counter=POLL_DIV-1.
- ext_enable rises in the same cycle as the first strobe and falls on the cycle after the last sample.
- Full GET: 4·STB_GAP cycles with enable high. Early-exit GET: STB_GAP cycles. SET: 4·STB_GAP cycles.
- msg_valid is asserted on the cycle after the word-3 sample.
- rsp_ready falls the cycle after the handshake and stays low until IDLE is re-entered.
- Reset mid-transaction: all outputs return to their reset values asynchronously. The responder sees enable low and resynchronizes.
- no_dev clears only on reset.

## Test plan
- Responder model with cd_req=0x00, POLL_DIV=32: polls every 32 cycles; each has exactly one strobe with ext_dout=0x0034; no msg_valid.
- Model puts {16'h0000,16'h0000,16'h00FF} (cd_req becomes 1): next poll has 4 strobes; msg_valid=1 with msg_data=0x0000_0000_00FF and msg_lost=0.
- Model puts 3 messages before a poll, last being {32'h0000_1234,16'h0036}: msg_data=0x0000_1234_0036, msg_lost=1, last_cnt=3.
- rsp_data=0x0000_0010_0003 offered while a poll is also due: SET goes first with ext_dout 0x0035, 0x0003, 0x0010, 0x0000. The model's cd_out equals rsp_data after enable falls, then the poll runs.
- Model holds ext_dout_en=0: no_dev=1 after the first sample, enable drops, no msg_valid.
- Assert reset_n low during word 2 of a GET: all outputs go to 0 immediately. After release, the first poll re-reads the counter from last_cnt=0.

Source files
------------

// File: rtl/ext_bus_host.sv
// Host-side initiator for the EXT_BUS CD mailbox: polls CD_GET for new core messages and
// issues CD_SET transactions carrying 48-bit replies.
module ext_bus_host #(
    parameter int unsigned POLL_DIV = 1024,
    parameter int unsigned STB_GAP  = 3,
    parameter int unsigned IDLE_GAP = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    output logic        ext_enable,
    output logic        ext_strobe,
    output logic [15:0] ext_dout,
    input  logic [15:0] ext_din,
    input  logic        ext_dout_en,
    output logic [47:0] msg_data,
    output logic        msg_valid,
    output logic        msg_lost,
    input  logic [47:0] rsp_data,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    output logic        busy,
    output logic        no_dev
);

    localparam int unsigned PollW = $clog2(POLL_DIV);
    localparam int unsigned WaitW = $clog2(STB_GAP);
    localparam int unsigned GapW  = $clog2(IDLE_GAP);

    localparam logic [PollW-1:0] PollReload = PollW'(POLL_DIV - 1);
    localparam logic [WaitW-1:0] WaitReload = WaitW'(STB_GAP - 2);
    localparam logic [GapW-1:0]  GapReload  = GapW'(IDLE_GAP - 1);

    localparam logic [15:0] CmdGet = 16'h0034;
    localparam logic [15:0] CmdSet = 16'h0035;

    typedef enum logic [1:0] {StIdle, StStrobe, StWait, StGap} state_e;

    state_e           state_q;
    logic [PollW-1:0] poll_q;
    logic [WaitW-1:0] wait_q;
    logic [GapW-1:0]  gap_q;
    logic [1:0]       word_q;
    logic             is_set_q;
    logic [47:0]      rsp_q;
    logic [7:0]       cnt_new_q;
    logic [7:0]       last_cnt_q;
    logic [31:0]      shadow_q;

    logic             ext_enable_q;
    logic             ext_strobe_q;
    logic [15:0]      ext_dout_q;
    logic [47:0]      msg_data_q;
    logic             msg_valid_q;
    logic             msg_lost_q;
    logic             rsp_ready_q;
    logic             busy_q;
    logic             no_dev_q;

    logic             abort;
    logic             no_change;
    logic             end_txn;
    logic [1:0]       next_word;
    logic [7:0]       cnt_diff;

    // Word presented with the strobe for a given slot of a GET or SET.
    function automatic logic [15:0] word_of(input logic set, input logic [1:0] idx,
                                            input logic [47:0] rsp);
        logic [15:0] w;
        w = 16'h0000;
        if (set) begin
            unique case (idx)
                2'd0: w = CmdSet;
                2'd1: w = rsp[15:0];
                2'd2: w = rsp[31:16];
                2'd3: w = rsp[47:32];
            endcase
        end else if (idx == 2'd0) begin
            w = CmdGet;
        end
        return w;
    endfunction

    always_comb begin
        abort     = (word_q == 2'd0) && !ext_dout_en;
        no_change = !is_set_q && (word_q == 2'd0) && (ext_din[7:0] == last_cnt_q);
        end_txn   = abort || no_change || (word_q == 2'd3);
        next_word = word_q + 2'd1;
        cnt_diff  = cnt_new_q - last_cnt_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            poll_q       <= PollReload;
            wait_q       <= '0;
            gap_q        <= '0;
            word_q       <= 2'd0;
            is_set_q     <= 1'b0;
            rsp_q        <= '0;
            cnt_new_q    <= 8'h00;
            last_cnt_q   <= 8'h00;
            shadow_q     <= '0;
            ext_enable_q <= 1'b0;
            ext_strobe_q <= 1'b0;
            ext_dout_q   <= 16'h0000;
            msg_data_q   <= '0;
            msg_valid_q  <= 1'b0;
            msg_lost_q   <= 1'b0;
            rsp_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            no_dev_q     <= 1'b0;
        end else begin
            ext_strobe_q <= 1'b0;
            msg_valid_q  <= 1'b0;
            // Counter parks at zero so an expiry during a SET stays pending.
            if (poll_q != '0) begin
                poll_q <= poll_q - 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    rsp_ready_q <= 1'b1;
                    if (rsp_valid && rsp_ready_q) begin
                        rsp_q        <= rsp_data;
                        is_set_q     <= 1'b1;
                        word_q       <= 2'd0;
                        state_q      <= StStrobe;
                        ext_enable_q <= 1'b1;
                        ext_strobe_q <= 1'b1;
                        ext_dout_q   <= CmdSet;
                        busy_q       <= 1'b1;
                        rsp_ready_q  <= 1'b0;
                    end else if (poll_q == '0) begin
                        poll_q       <= PollReload;
                        is_set_q     <= 1'b0;
                        word_q       <= 2'd0;
                        state_q      <= StStrobe;
                        ext_enable_q <= 1'b1;
                        ext_strobe_q <= 1'b1;
                        ext_dout_q   <= CmdGet;
                        busy_q       <= 1'b1;
                        rsp_ready_q  <= 1'b0;
                    end
                end

                StStrobe: begin
                    state_q    <= StWait;
                    wait_q     <= WaitReload;
                    ext_dout_q <= 16'h0000;
                end

                StWait: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 1'b1;
                    end else begin
                        if (abort) begin
                            no_dev_q <= 1'b1;
                        end
                        if (!is_set_q && !abort) begin
                            unique case (word_q)
                                2'd0: cnt_new_q       <= ext_din[7:0];
                                2'd1: shadow_q[15:0]  <= ext_din;
                                2'd2: shadow_q[31:16] <= ext_din;
                                2'd3: begin
                                    msg_data_q  <= {ext_din, shadow_q};
                                    msg_valid_q <= 1'b1;
                                    msg_lost_q  <= (cnt_diff > 8'd1);
                                    last_cnt_q  <= cnt_new_q;
                                end
                            endcase
                        end
                        if (end_txn) begin
                            state_q      <= StGap;
                            gap_q        <= GapReload;
                            ext_enable_q <= 1'b0;
                        end else begin
                            state_q      <= StStrobe;
                            word_q       <= next_word;
                            ext_strobe_q <= 1'b1;
                            ext_dout_q   <= word_of(is_set_q, next_word, rsp_q);
                        end
                    end
                end

                StGap: begin
                    if (gap_q == '0) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        rsp_ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign ext_enable = ext_enable_q;
    assign ext_strobe = ext_strobe_q;
    assign ext_dout   = ext_dout_q;
    assign msg_data   = msg_data_q;
    assign msg_valid  = msg_valid_q;
    assign msg_lost   = msg_lost_q;
    assign rsp_ready  = rsp_ready_q;
    assign busy       = busy_q;
    assign no_dev     = no_dev_q;

endmodule
